mul_shift_add_ctrl: RTL

//  Multi-cycle unsigned 32x32->64 multiplier sequencer for the RV32 core's MUL/MULHU path.

---
 rtl/mul_shift_add_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mul_shift_add_ctrl.sv
// Multi-cycle unsigned 32x32->64 shift-add multiplier sequencer (IDLE -> CALC x32 -> DONE).
// Optional build macro MUL_ZERO_BYPASS_EN: a zero operand skips CALC and returns 0 immediately.
module mul_shift_add_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result_lo,
    output logic [XLEN-1:0] o_result_hi
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   res_lo_q, res_lo_d;
    logic [XLEN-1:0]   res_hi_q, res_hi_d;

    logic [XLEN-1:0]   add_sum;
    logic              add_carry;
    logic [XLEN-1:0]   step_acc;
    logic [XLEN-1:0]   step_mplier;
    logic              zero_bypass;

    // Shared 32-bit adder, add mode with carry-in 0; its carry-out becomes acc's new MSB.
    assign {add_carry, add_sum} = {1'b0, acc_q} + {1'b0, mcand_q};

    always_comb begin
        if (mplier_q[0]) begin
            step_acc    = {add_carry, add_sum[XLEN-1:1]};
            step_mplier = {add_sum[0], mplier_q[XLEN-1:1]};
        end else begin
            step_acc    = {1'b0, acc_q[XLEN-1:1]};
            step_mplier = {acc_q[0], mplier_q[XLEN-1:1]};
        end
    end

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_bypass = (i_op_a == '0) || (i_op_b == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d takes its hold value first so no path through the case infers a latch.
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mcand_d  = i_op_a;
                    mplier_d = i_op_b;
                    acc_d    = '0;
                    count_d  = '0;
                    if (zero_bypass) begin
                        state_d  = S_DONE;
                        res_lo_d = '0;
                        res_hi_d = '0;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d    = step_acc;
                mplier_d = step_mplier;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_STEP) begin
                    state_d  = S_DONE;
                    res_hi_d = step_acc;
                    res_lo_d = step_mplier;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

    assign o_ready     = (state_q == S_IDLE);
    assign o_busy      = (state_q == S_CALC);
    assign o_done      = (state_q == S_DONE);
    assign o_result_lo = res_lo_q;
    assign o_result_hi = res_hi_q;

endmodule
